// File: rtl/sdram_qos_arbiter.sv
// SDRAM arbiter: fixed-priority video port 0, round-robin for ports 1..N-1, starvation override.
// Optional grant/override statistics counters enabled by defining SDRAM_QOS_ARB_STATS_EN.
module sdram_qos_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int STARVE_LIMIT = 64,
    parameter int WAITSTATES   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_rd,
    input  logic [NUM_REQ-1:0]      req_wr,
    input  logic [NUM_REQ-1:0]      req_burst,
    input  logic [24*NUM_REQ-1:0]   req_addr_x16,
    input  logic [16*NUM_REQ-1:0]   req_wdata,
    input  logic [2*NUM_REQ-1:0]    req_wmask,
    input  logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      req_rdy,
    output logic [NUM_REQ-1:0]      req_resp_valid,
    output logic [15:0]             req_rdata,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    sdram_rd,
    output logic                    sdram_wr,
    output logic                    sdram_burst,
    output logic                    sdram_ack,
    output logic [23:0]             sdram_addr_x16,
    output logic [15:0]             sdram_wdata,
    output logic [1:0]              sdram_wmask,
`ifdef SDRAM_QOS_ARB_STATS_EN
    input  logic [1:0]              stat_sel,
    input  logic                    stat_clr,
    output logic [15:0]             stat_count,
`endif
    input  logic                    sdram_rdy,
    input  logic                    sdram_resp_valid,
    input  logic [15:0]             sdram_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (WAITSTATES > 0) ? $clog2(WAITSTATES + 1) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]      ws_q, ws_d;
    logic [SW-1:0]      starve_q [NUM_REQ];
    logic [SW-1:0]      starve_d [NUM_REQ];
    logic [NUM_REQ-1:0] pend;
    logic               win, win_ovr;
    logic [1:0]         win_idx, own_idx;
    logic               own_ack;

    assign pend  = req_rd | req_wr;
    assign grant = grant_q;

    // k-th non-video port searching upward from base, wrapping NUM_REQ-1 back to 1
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - (NUM_REQ - 1);
        return 2'(s);
    endfunction

    always_comb begin
        win     = 1'b0;
        win_ovr = 1'b0;
        win_idx = 2'd0;
        if (state_q == IDLE) begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                if (!win && pend[rr_idx(rr_ptr_q, k)] &&
                    starve_q[rr_idx(rr_ptr_q, k)] == SW'(STARVE_LIMIT)) begin
                    win     = 1'b1;
                    win_ovr = 1'b1;
                    win_idx = rr_idx(rr_ptr_q, k);
                end
            end
            if (!win && pend[0]) begin
                win     = 1'b1;
                win_idx = 2'd0;
            end
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                if (!win && pend[rr_idx(rr_ptr_q, k)]) begin
                    win     = 1'b1;
                    win_idx = rr_idx(rr_ptr_q, k);
                end
            end
        end
    end

    always_comb begin
        own_idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) own_idx = 2'(i);
        end
    end

    assign own_ack = (|grant_q) && req_ack[own_idx];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        ws_d     = ws_q;
        case (state_q)
            IDLE: begin
                if (win) begin
                    state_d = OWNED;
                    grant_d = NUM_REQ'(1) << win_idx;
                    ws_d    = WW'(WAITSTATES);
                    if (win_idx != 2'd0)
                        rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? 2'd1 : win_idx + 2'd1;
                end
            end
            OWNED: begin
                if (ws_q != '0) ws_d = ws_q - WW'(1);
                if (own_ack) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    // a port's wait is measured against the registered grant, so it clears the cycle after winning
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) starve_d[i] = starve_q[i];
        starve_d[0] = '0;
        for (int i = 1; i < NUM_REQ; i++) begin
            if (!pend[i] || grant_q[i])
                starve_d[i] = '0;
            else if (starve_q[i] != SW'(STARVE_LIMIT))
                starve_d[i] = starve_q[i] + SW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= 2'd1;
            ws_q     <= '0;
            for (int i = 0; i < NUM_REQ; i++) starve_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            ws_q     <= ws_d;
            for (int i = 0; i < NUM_REQ; i++) starve_q[i] <= starve_d[i];
        end
    end

    always_comb begin
        sdram_rd       = 1'b0;
        sdram_wr       = 1'b0;
        sdram_burst    = 1'b0;
        sdram_ack      = 1'b0;
        sdram_addr_x16 = '0;
        sdram_wdata    = '0;
        sdram_wmask    = '0;
        req_rdy        = '0;
        req_resp_valid = '0;
        req_rdata      = sdram_rdata;
        if (|grant_q) begin
            sdram_rd                = req_rd[own_idx];
            sdram_wr                = req_wr[own_idx];
            sdram_burst             = req_burst[own_idx];
            sdram_ack               = req_ack[own_idx];
            sdram_addr_x16          = req_addr_x16[int'(own_idx)*24 +: 24];
            sdram_wdata             = req_wdata[int'(own_idx)*16 +: 16];
            sdram_wmask             = req_wmask[int'(own_idx)*2 +: 2];
            req_rdy[own_idx]        = sdram_rdy && (ws_q == '0);
            req_resp_valid[own_idx] = sdram_resp_valid;
        end
    end

`ifdef SDRAM_QOS_ARB_STATS_EN
    // with four ports there is no spare slot, so override events share port 3's counter
    localparam int OVR_IDX = (NUM_REQ < 4) ? NUM_REQ : 3;

    logic [15:0] stat_q [4];
    logic [15:0] stat_d [4];
    logic [15:0] stat_count_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [16:0] sum;
            sum = {1'b0, stat_q[i]}
                + 17'(win && (int'(win_idx) == i))
                + 17'(win_ovr && (i == OVR_IDX));
            stat_d[i] = sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) stat_q[i] <= '0;
            stat_count_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) stat_q[i] <= stat_clr ? 16'h0000 : stat_d[i];
            stat_count_q <= stat_q[stat_sel];
        end
    end

    assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_sdram_qos_arbiter.sv
// Self-checking bench for sdram_qos_arbiter (3 ports, starvation limit 8, 2 waitstates).
module tb_sdram_qos_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  req_rd = '0, req_wr = '0, req_burst = '0, req_ack = '0;
    logic [71:0] req_addr_x16 = '0;
    logic [47:0] req_wdata = '0;
    logic [5:0]  req_wmask = '0;
    logic [2:0]  req_rdy, req_resp_valid, grant;
    logic [15:0] req_rdata;
    logic        sdram_rd, sdram_wr, sdram_burst, sdram_ack;
    logic [23:0] sdram_addr_x16;
    logic [15:0] sdram_wdata;
    logic [1:0]  sdram_wmask;
    logic        sdram_rdy = 1'b0, sdram_resp_valid = 1'b0;
    logic [15:0] sdram_rdata = '0;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    typedef struct {
        logic [2:0] g;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    sdram_qos_arbiter #(.NUM_REQ(3), .STARVE_LIMIT(8), .WAITSTATES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_rd(req_rd), .req_wr(req_wr), .req_burst(req_burst),
        .req_addr_x16(req_addr_x16), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .req_ack(req_ack), .req_rdy(req_rdy), .req_resp_valid(req_resp_valid),
        .req_rdata(req_rdata), .grant(grant),
        .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_burst(sdram_burst),
        .sdram_ack(sdram_ack), .sdram_addr_x16(sdram_addr_x16),
        .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask),
        .sdram_rdy(sdram_rdy), .sdram_resp_valid(sdram_resp_valid),
        .sdram_rdata(sdram_rdata)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        req_rd = '0; req_wr = '0; req_burst = '0; req_ack = '0;
        req_addr_x16 = '0; req_wdata = '0; req_wmask = '0;
        sdram_rdy = 1'b0; sdram_resp_valid = 1'b0; sdram_rdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // One clock; owners ack immediately, non-persistent ports drop their request once acked.
    task automatic drive_cycle(input logic [2:0] persist);
        logic [2:0] prev_ack;
        prev_ack = req_ack;
        @(posedge clk_i);
        #1;
        cyc_n++;
        for (int i = 0; i < 3; i++) begin
            if (prev_ack[i] && !persist[i]) begin
                req_rd[i] = 1'b0;
                req_wr[i] = 1'b0;
            end
        end
        req_ack = grant;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        req_rd[0] = 1'b1;
        sdram_rdy = 1'b1;
        req_addr_x16[23:0] = 24'hABCDEF;
        @(posedge clk_i);
        #1;
        checks++; if (grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", grant); end
        checks++; if (req_rdy !== 3'b000) begin failures++; $display("FAIL reset_rdy got=%b exp=000", req_rdy); end
        checks++; if ({sdram_rd, sdram_wr, sdram_burst, sdram_ack} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {sdram_rd, sdram_wr, sdram_burst, sdram_ack}); end
        checks++; if (sdram_addr_x16 !== 24'h0 || sdram_wdata !== 16'h0 || sdram_wmask !== 2'b00) begin
            failures++; $display("FAIL reset_data got=%h/%h/%b exp=0", sdram_addr_x16, sdram_wdata, sdram_wmask); end
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++; if (grant !== 3'b001) begin failures++; $display("FAIL reset_first_grant got=%b exp=001", grant); end
        checks++; if (sdram_addr_x16 !== 24'hABCDEF) begin
            failures++; $display("FAIL reset_addr_mux got=%h exp=abcdef", sdram_addr_x16); end
        req_ack[0] = 1'b1;
        @(posedge clk_i);
        #1;
        req_rd = '0; req_ack = '0;
    endtask

    task automatic test_cpu_read();
        apply_reset();
        sdram_rdy = 1'b1;
        req_addr_x16[47:24] = 24'h000100;
        req_wdata[31:16] = 16'h1234;
        req_wmask[3:2] = 2'b10;
        req_burst[1] = 1'b1;
        req_rd[1] = 1'b1;
        @(posedge clk_i);
        #1;
        checks++; if (grant !== 3'b010) begin failures++; $display("FAIL cpu_grant got=%b exp=010", grant); end
        checks++; if (sdram_addr_x16 !== 24'h000100) begin failures++; $display("FAIL cpu_addr got=%h exp=000100", sdram_addr_x16); end
        checks++; if ({sdram_rd, sdram_wr, sdram_burst} !== 3'b101) begin
            failures++; $display("FAIL cpu_ctrl got=%b exp=101", {sdram_rd, sdram_wr, sdram_burst}); end
        checks++; if (sdram_wdata !== 16'h1234 || sdram_wmask !== 2'b10) begin
            failures++; $display("FAIL cpu_wdata got=%h/%b exp=1234/10", sdram_wdata, sdram_wmask); end
        checks++; if (req_rdy !== 3'b000) begin failures++; $display("FAIL cpu_ws1 got=%b exp=000", req_rdy); end
        @(posedge clk_i);
        #1;
        checks++; if (req_rdy !== 3'b000) begin failures++; $display("FAIL cpu_ws2 got=%b exp=000", req_rdy); end
        sdram_resp_valid = 1'b1;
        sdram_rdata = 16'hBEEF;
        @(posedge clk_i);
        #1;
        checks++; if (req_rdy !== 3'b010) begin failures++; $display("FAIL cpu_rdy got=%b exp=010", req_rdy); end
        checks++; if (req_resp_valid !== 3'b010 || req_rdata !== 16'hBEEF) begin
            failures++; $display("FAIL cpu_resp got=%b/%h exp=010/beef", req_resp_valid, req_rdata); end
        req_ack[1] = 1'b1;
        #1;
        checks++; if (sdram_ack !== 1'b1) begin failures++; $display("FAIL cpu_ack_mux got=%b exp=1", sdram_ack); end
        @(posedge clk_i);
        #1;
        checks++; if (grant !== 3'b000 || sdram_rd !== 1'b0) begin
            failures++; $display("FAIL cpu_release got=%b/%b exp=000/0", grant, sdram_rd); end
        checks++; if (req_rdy !== 3'b000 || req_resp_valid !== 3'b000) begin
            failures++; $display("FAIL cpu_idle_out got=%b/%b exp=000/000", req_rdy, req_resp_valid); end
        clear_inputs();
    endtask

    task automatic test_priority();
        exp_t e;
        logic [2:0] prev_g;
        apply_reset();
        sb.push_back('{3'b001, 1});
        sb.push_back('{3'b010, 3});
        req_rd[0] = 1'b1;
        req_rd[1] = 1'b1;
        cyc_n = 0;
        prev_g = 3'b000;
        for (int c = 0; c < 6; c++) begin
            drive_cycle(3'b000);
            if (grant !== 3'b000 && prev_g === 3'b000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL prio_extra got=%b@%0d exp=none", grant, cyc_n);
                end else begin
                    e = sb.pop_front();
                    if (grant !== e.g || cyc_n != e.cyc) begin
                        failures++; $display("FAIL prio_grant got=%b@%0d exp=%b@%0d", grant, cyc_n, e.g, e.cyc);
                    end
                end
            end
            prev_g = grant;
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL prio_missing got=%0d pending exp=0", sb.size()); sb.delete(); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [2:0] prev_g;
        apply_reset();
        for (int k = 0; k < 4; k++) sb.push_back('{(k % 2 == 0) ? 3'b010 : 3'b100, 1 + 2 * k});
        req_rd[1] = 1'b1;
        req_wr[2] = 1'b1;
        cyc_n = 0;
        prev_g = 3'b000;
        for (int c = 0; c < 8; c++) begin
            drive_cycle(3'b110);
            if (grant !== 3'b000 && prev_g === 3'b000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL rr_extra got=%b@%0d exp=none", grant, cyc_n);
                end else begin
                    e = sb.pop_front();
                    if (grant !== e.g || cyc_n != e.cyc) begin
                        failures++; $display("FAIL rr_grant got=%b@%0d exp=%b@%0d", grant, cyc_n, e.g, e.cyc);
                    end
                end
            end
            prev_g = grant;
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL rr_missing got=%0d pending exp=0", sb.size()); sb.delete(); end
        req_rd = '0; req_wr = '0;
        for (int c = 0; c < 3; c++) drive_cycle(3'b000);
        clear_inputs();
    endtask

    task automatic test_starvation();
        exp_t e;
        logic [2:0] prev_g;
        apply_reset();
        for (int k = 0; k < 4; k++) sb.push_back('{3'b001, 1 + 2 * k});
        sb.push_back('{3'b010, 9});
        sb.push_back('{3'b001, 11});
        sb.push_back('{3'b001, 13});
        req_rd[0] = 1'b1;
        req_rd[1] = 1'b1;
        cyc_n = 0;
        prev_g = 3'b000;
        for (int c = 0; c < 14; c++) begin
            drive_cycle(3'b001);
            if (grant !== 3'b000 && prev_g === 3'b000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL starve_extra got=%b@%0d exp=none", grant, cyc_n);
                end else begin
                    e = sb.pop_front();
                    if (grant !== e.g || cyc_n != e.cyc) begin
                        failures++; $display("FAIL starve_grant got=%b@%0d exp=%b@%0d", grant, cyc_n, e.g, e.cyc);
                    end
                end
            end
            prev_g = grant;
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL starve_missing got=%0d pending exp=0", sb.size()); sb.delete(); end
        req_rd = '0;
        for (int c = 0; c < 3; c++) drive_cycle(3'b000);
        clear_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        sdram_rdy = 1'b1;
        req_wr[2] = 1'b1;
        req_addr_x16[71:48] = 24'h00F00D;
        @(posedge clk_i);
        #1;
        checks++; if (grant !== 3'b100) begin failures++; $display("FAIL arst_pre_grant got=%b exp=100", grant); end
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        checks++; if (req_rdy !== 3'b100 || sdram_wr !== 1'b1) begin
            failures++; $display("FAIL arst_pre_rdy got=%b/%b exp=100/1", req_rdy, sdram_wr); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (grant !== 3'b000) begin failures++; $display("FAIL arst_grant got=%b exp=000", grant); end
        checks++; if (sdram_rd !== 1'b0 || sdram_wr !== 1'b0 || req_rdy !== 3'b000) begin
            failures++; $display("FAIL arst_outputs got=%b/%b/%b exp=0/0/000", sdram_rd, sdram_wr, req_rdy); end
        req_wr = '0;
        req_rd[0] = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++; if (grant !== 3'b001) begin failures++; $display("FAIL arst_post_grant got=%b exp=001", grant); end
        req_ack[0] = 1'b1;
        @(posedge clk_i);
        #1;
        clear_inputs();
    endtask

    task automatic test_nonowner_ack();
        apply_reset();
        req_rd[1] = 1'b1;
        @(posedge clk_i);
        #1;
        checks++; if (grant !== 3'b010) begin failures++; $display("FAIL nack_grant got=%b exp=010", grant); end
        req_ack[2] = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (grant !== 3'b010 || sdram_rd !== 1'b1) begin
            failures++; $display("FAIL nack_hold got=%b/%b exp=010/1", grant, sdram_rd); end
        req_ack = 3'b010;
        @(posedge clk_i);
        #1;
        checks++; if (grant !== 3'b000) begin failures++; $display("FAIL nack_release got=%b exp=000", grant); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_priority();
        test_round_robin();
        test_starvation();
        test_async_reset();
        test_nonowner_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_qos_arbiter.md
Name: sdram_qos_arbiter

Overview:
N-port SDRAM arbiter that sits between the SDRAM controller and its requesters: video scanout, CPU, and a DMA/blitter port. Port 0 (video) has fixed top priority. The remaining ports are served round-robin. A starvation timer lets a waiting non-video port overtake video. Exactly one transaction owns the controller at a time, from grant until the owner's ack.

Parameters:
NUM_REQ, 3, number of requester ports (2..4); port 0 is the real-time video port.
STARVE_LIMIT, 64, cycles a pending non-video request may wait before it gains priority over port 0.
WAITSTATES, 2, cycles after grant during which sdram_rdy is masked from the owner.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_rd  in  NUM_REQ  per-port read request, held until the port's ack
req_wr  in  NUM_REQ  per-port write request, held until ack (port 0 ties low)
req_burst  in  NUM_REQ  per-port burst flag
req_addr_x16  in  24*NUM_REQ  packed per-port word address; port i is bits [24i+23:24i]
req_wdata  in  16*NUM_REQ  packed per-port write data
req_wmask  in  2*NUM_REQ  packed per-port byte mask
req_ack  in  NUM_REQ  per-port transaction-complete acknowledge
req_rdy  out  NUM_REQ  per-port controller-ready
req_resp_valid  out  NUM_REQ  per-port read data valid
req_rdata  out  16  read data, broadcast to all ports
grant  out  NUM_REQ  one-hot owner, registered
sdram_rd, sdram_wr, sdram_burst, sdram_ack  out  1 each  muxed to the controller
sdram_addr_x16 out 24; sdram_wdata out 16; sdram_wmask out 2  muxed from the owner
sdram_rdy  in  1  controller ready
sdram_resp_valid  in  1  controller read data valid
sdram_rdata  in  16  controller read data

Behaviour:
- States: IDLE, OWNED. Reset value: IDLE, grant=0, rr_ptr=1, all starvation counters=0, waitstate counter=0.
- Reset is asynchronous. Assertion mid-transaction drops ownership immediately, and all outputs return to their idle values in the same cycle.
- IDLE: a port is pending when req_rd|req_wr is high. Winner selection, evaluated in this order:
  - (a) Any non-video port whose starve_cnt has reached STARVE_LIMIT wins. If several have, the lowest index from rr_ptr wins.
  - (b) Otherwise, port 0 wins if pending.
  - (c) Otherwise, the first pending port searching upward from rr_ptr, wrapping NUM_REQ-1 to 1.
- On a win: grant <= onehot(winner), state <= OWNED, waitstate counter <= WAITSTATES. For a non-video winner, rr_ptr <= winner+1, wrapping to 1.
- OWNED:
  - The waitstate counter decrements to 0.
  - When req_ack[owner] is high, the next cycle has state=IDLE and grant=0.
  - There is always one IDLE cycle between transactions. An ack and a new request in the same cycle therefore yield the next grant 2 cycles after the ack.
- Starvation counters, one per non-video port:
  - Increment (saturating at STARVE_LIMIT) each cycle the port is pending and not granted.
  - Clear when the port is granted or when it is not pending.
- Output mux (combinational from grant):
  - Owner's rd/wr/burst/addr/wdata/wmask/ack drive the sdram_* outputs.
  - req_rdy[owner] = sdram_rdy && waitstate counter==0. req_resp_valid[owner] = sdram_resp_valid.
  - All other req_rdy and req_resp_valid bits are 0.
  - With grant=0: sdram_rd/wr/ack/burst=0, and addr/wdata/wmask=0 (no X on outputs).
- A requester dropping rd/wr before its ack is a protocol violation. The arbiter keeps ownership until the ack regardless.
- An ack from a non-owner is ignored.

Optional Feature:
SDRAM_QOS_ARB_STATS_EN
- Defined:
  - Adds inputs stat_sel[1:0] and stat_clr, and output stat_count[15:0].
  - Maintains one 16-bit saturating grant counter per port, plus one starvation-override event counter at index NUM_REQ if NUM_REQ<4, else merged into port 3's counter.
  - stat_count = counter[stat_sel], registered, 1-cycle latency.
  - stat_clr zeroes all counters. Reset clears them.
- Undefined: these ports and counters do not exist, and arbitration is identical.

Test Plan:
- Only CPU (port 1) reads at addr 24'h000100 -> grant=3'b010 one cycle later. req_rdy[1] stays low for 2 cycles even with sdram_rdy=1. sdram_addr_x16=24'h000100. resp_valid and rdata are routed to port 1 only. The ack returns grant to 0 in the next cycle.
- Ports 0 and 1 request in the same IDLE cycle -> port 0 granted first. After port 0's ack, one idle cycle, then port 1 is granted.
- Ports 1 and 2 request continuously with immediate acks -> grants alternate 1,2,1,2 with one idle cycle between them.
- Port 0 requests back-to-back while port 1 waits, STARVE_LIMIT=8 -> after 8 waiting cycles, port 1 wins at the next IDLE despite port 0 pending. starve_cnt[1] then returns to 0.
- Async reset asserted mid-transfer while grant=3'b100 -> grant=0, sdram_rd=sdram_wr=0, and all req_rdy=0 before the next clock edge. After release, a pending port 0 is granted in the first cycle.
- An ack on port 2 while port 1 owns the controller -> ownership unchanged. With SDRAM_QOS_ARB_STATS_EN defined, three port-1 grants then stat_sel=1 -> stat_count=3 one cycle later.
